// File: rtl/data_mem_arbiter_if.sv
// Requester-side and memory-side signals of the two-master data memory arbiter.
// The arbiter uses the slave view; the requesters and memory side use the master view.
interface data_mem_arbiter_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
);
  logic                  m0_req;
  logic                  m1_req;
  logic                  m0_we;
  logic                  m1_we;
  logic [ADDR_WIDTH-1:0] m0_addr;
  logic [ADDR_WIDTH-1:0] m1_addr;
  logic [DATA_WIDTH-1:0] m0_wd;
  logic [DATA_WIDTH-1:0] m1_wd;
  logic                  m0_ack;
  logic                  m1_ack;
  logic [DATA_WIDTH-1:0] m0_rd;
  logic [DATA_WIDTH-1:0] m1_rd;
  logic                  mem_we;
  logic                  mem_re;
  logic [ADDR_WIDTH-1:0] mem_address;
  logic [DATA_WIDTH-1:0] mem_wd;
  logic [DATA_WIDTH-1:0] mem_rd;
  logic                  busy;
  logic                  gnt_id;

  modport slave (
    input  m0_req, m1_req, m0_we, m1_we, m0_addr, m1_addr, m0_wd, m1_wd, mem_rd,
    output m0_ack, m1_ack, m0_rd, m1_rd, mem_we, mem_re, mem_address, mem_wd,
           busy, gnt_id
  );

  modport master (
    output m0_req, m1_req, m0_we, m1_we, m0_addr, m1_addr, m0_wd, m1_wd, mem_rd,
    input  m0_ack, m1_ack, m0_rd, m1_rd, mem_we, mem_re, mem_address, mem_wd,
           busy, gnt_id
  );
endinterface

// File: rtl/data_mem_arbiter.sv
// Round-robin arbiter sharing one async-read/sync-write data memory between two masters.
// Each access runs IDLE -> ACCESS (memory cycle) -> RESP (one-cycle ack).
module data_mem_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
) (
  input  logic              clk,
  input  logic              rst,
  data_mem_arbiter_if.slave bus
);
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  state_t                r_state;
  state_t                w_state_next;
  logic                  r_last_grant;
  logic                  r_gnt_id;
  logic                  r_cmd_we;
  logic [ADDR_WIDTH-1:0] r_cmd_addr;
  logic [DATA_WIDTH-1:0] r_cmd_wd;
  logic [DATA_WIDTH-1:0] r_m0_rd;
  logic [DATA_WIDTH-1:0] r_m1_rd;
  logic                  w_grant;
  logic                  w_winner;
  logic                  w_winner_we;
  logic [ADDR_WIDTH-1:0] w_winner_addr;
  logic [DATA_WIDTH-1:0] w_winner_wd;

  // A lone requester wins outright; on a tie the master not granted last time wins.
  assign w_winner      = (bus.m0_req && bus.m1_req) ? ~r_last_grant : bus.m1_req;
  assign w_winner_we   = w_winner ? bus.m1_we   : bus.m0_we;
  assign w_winner_addr = w_winner ? bus.m1_addr : bus.m0_addr;
  assign w_winner_wd   = w_winner ? bus.m1_wd   : bus.m0_wd;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_grant      = 1'b0;
    bus.mem_we   = 1'b0;
    bus.mem_re   = 1'b0;
    bus.m0_ack   = 1'b0;
    bus.m1_ack   = 1'b0;
    case (r_state)
      IDLE: begin
        if (bus.m0_req || bus.m1_req) begin
          w_grant      = 1'b1;
          w_state_next = ACCESS;
        end
      end
      ACCESS: begin
        bus.mem_we   = r_cmd_we;
        bus.mem_re   = ~r_cmd_we;
        w_state_next = RESP;
      end
      RESP: begin
        bus.m0_ack   = ~r_gnt_id;
        bus.m1_ack   = r_gnt_id;
        w_state_next = IDLE;
      end
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_last_grant <= 1'b1;
      r_gnt_id     <= 1'b0;
      r_cmd_we     <= 1'b0;
      r_cmd_addr   <= '0;
      r_cmd_wd     <= '0;
      r_m0_rd      <= '0;
      r_m1_rd      <= '0;
    end else begin
      if (w_grant) begin
        r_last_grant <= w_winner;
        r_gnt_id     <= w_winner;
        r_cmd_we     <= w_winner_we;
        r_cmd_addr   <= w_winner_addr;
        r_cmd_wd     <= w_winner_wd;
      end
      // Read data lands in the granted master's register; writes leave it untouched.
      if (r_state == ACCESS && !r_cmd_we) begin
        if (r_gnt_id) begin
          r_m1_rd <= bus.mem_rd;
        end else begin
          r_m0_rd <= bus.mem_rd;
        end
      end
    end
  end

  assign bus.mem_address = r_cmd_addr;
  assign bus.mem_wd      = r_cmd_wd;
  assign bus.m0_rd       = r_m0_rd;
  assign bus.m1_rd       = r_m1_rd;
  assign bus.busy        = (r_state != IDLE);
  assign bus.gnt_id      = r_gnt_id;
endmodule

// File: tb/tb_data_mem_arbiter.sv
// Scoreboard bench for data_mem_arbiter: a slot-level reference model predicts each access
// and ack; a negedge monitor compares the DUT and a 64-word data memory model against it.
module tb_data_mem_arbiter;
  localparam int DW = 32;
  localparam int AW = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;

  data_mem_arbiter_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  data_mem_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          m;
    bit          we;
    logic [31:0] addr;
    logic [31:0] wd;
    logic [31:0] rd0;
    logic [31:0] rd1;
    int          acc_cyc;
    int          ack_cyc;
  } exp_t;

  int          n_tests    = 0;
  int          n_fail     = 0;
  int          cyc        = 0;
  int          next_free  = 0;
  int          exp_writes = 0;
  int          act_writes = 0;
  bit          ref_last   = 1'b1;
  bit          mon_en     = 1'b0;
  bit          pre_en     = 1'b0;
  logic [5:0]  pre_addr   = '0;
  logic [31:0] pre_data   = '0;
  logic [31:0] ref_mem  [64];
  logic [31:0] rd_model [2];
  logic [31:0] mem_arr  [64];
  exp_t        q [$];

  // Data memory: asynchronous read, synchronous write.
  assign bus.mem_rd = mem_arr[bus.mem_address[5:0]];

  always @(posedge clk) begin
    if (pre_en) begin
      mem_arr[pre_addr] <= pre_data;
    end else if (bus.mem_we) begin
      mem_arr[bus.mem_address[5:0]] <= bus.mem_wd;
      act_writes <= act_writes + 1;
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @cyc %0d: got 0x%0h, expected 0x%0h", name, cyc, act, exp);
    end
  endtask

  // Reference model: one access per 3-cycle slot, round-robin among simultaneous requests.
  always @(posedge clk) begin
    exp_t e;
    bit   w;
    cyc = cyc + 1;
    if (pre_en) ref_mem[pre_addr] = pre_data;
    if (rst) begin
      q.delete();
      ref_last    = 1'b1;
      next_free   = 0;
      rd_model[0] = '0;
      rd_model[1] = '0;
    end else if (cyc >= next_free && (bus.m0_req || bus.m1_req)) begin
      if (bus.m0_req && bus.m1_req) w = !ref_last;
      else                          w = bus.m1_req;
      ref_last = w;
      e.m    = w;
      e.we   = w ? bus.m1_we   : bus.m0_we;
      e.addr = w ? bus.m1_addr : bus.m0_addr;
      e.wd   = w ? bus.m1_wd   : bus.m0_wd;
      if (e.we) begin
        ref_mem[e.addr[5:0]] = e.wd;
        exp_writes++;
      end else begin
        rd_model[w] = ref_mem[e.addr[5:0]];
      end
      e.rd0     = rd_model[0];
      e.rd1     = rd_model[1];
      e.acc_cyc = cyc;
      e.ack_cyc = cyc + 1;
      next_free = cyc + 3;
      q.push_back(e);
    end
  end

  always @(negedge clk) begin
    bit exp_acc;
    bit exp_ack;
    if (mon_en) begin
      exp_acc = (q.size() > 0) && (q[0].acc_cyc == cyc);
      exp_ack = (q.size() > 0) && (q[0].ack_cyc == cyc);
      check("busy", bus.busy, exp_acc || exp_ack);
      if (exp_acc) begin
        check("acc_we", bus.mem_we, q[0].we);
        check("acc_re", bus.mem_re, !q[0].we);
        check("acc_addr", bus.mem_address, q[0].addr);
        if (q[0].we) check("acc_wd", bus.mem_wd, q[0].wd);
        check("acc_gnt", bus.gnt_id, q[0].m);
      end else begin
        check("idle_mem", {bus.mem_we, bus.mem_re}, 2'b00);
      end
      if (exp_ack) begin
        check("ack_onehot", {bus.m1_ack, bus.m0_ack}, q[0].m ? 2'b10 : 2'b01);
        check("ack_gnt", bus.gnt_id, q[0].m);
        check("m0_rd", bus.m0_rd, q[0].rd0);
        check("m1_rd", bus.m1_rd, q[0].rd1);
        void'(q.pop_front());
      end else begin
        check("no_ack", {bus.m1_ack, bus.m0_ack}, 2'b00);
      end
    end
  end

  task automatic set_req(input bit m, input bit v);
    if (m) bus.m1_req = v;
    else   bus.m0_req = v;
  endtask

  task automatic set_cmd(input bit m, input bit we, input logic [31:0] a, input logic [31:0] d);
    if (m) begin
      bus.m1_we = we; bus.m1_addr = a; bus.m1_wd = d; bus.m1_req = 1'b1;
    end else begin
      bus.m0_we = we; bus.m0_addr = a; bus.m0_wd = d; bus.m0_req = 1'b1;
    end
  endtask

  // Raises a request and waits for its ack; req is left high for the caller to drop or reuse.
  task automatic do_req(input bit m, input bit we, input logic [31:0] a, input logic [31:0] d,
                        output int lat);
    bit acked;
    set_cmd(m, we, a, d);
    lat   = 0;
    acked = 1'b0;
    while (!acked && lat < 40) begin
      @(negedge clk);
      lat++;
      acked = m ? bus.m1_ack : bus.m0_ack;
    end
    if (!acked) check("ack_timeout", 0, 1);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic contend(input bit m);
    int lat;
    for (int i = 0; i < 4; i++) begin
      do_req(m, i[0], 32'(8 + 2 * i + int'(m)), $urandom(), lat);
    end
    set_req(m, 1'b0);
  endtask

  task automatic rand_traffic(input bit m, input int n);
    int          lat;
    int          g;
    logic [31:0] a;
    for (int i = 0; i < n; i++) begin
      a = ($urandom() & 32'hFFFF_FFC0) | 32'($urandom_range(0, 63));
      do_req(m, 1'($urandom_range(0, 1)), a, $urandom(), lat);
      g = $urandom_range(0, 2);
      if (g != 0) begin
        set_req(m, 1'b0);
        repeat (g) @(negedge clk);
      end
    end
    set_req(m, 1'b0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int lat;
    int lat0;
    int lat1;
    bus.m0_req = 0; bus.m0_we = 0; bus.m0_addr = '0; bus.m0_wd = '0;
    bus.m1_req = 0; bus.m1_we = 0; bus.m1_addr = '0; bus.m1_wd = '0;

    @(negedge clk);
    pre_en = 1'b1;
    for (int a = 0; a < 64; a++) begin
      pre_addr = 6'(a);
      pre_data = (a == 20) ? 32'hDEAD_BEEF : $urandom();
      @(negedge clk);
    end
    pre_en = 1'b0;

    check("rst_busy", bus.busy, 0);
    check("rst_acks", {bus.m1_ack, bus.m0_ack}, 0);
    check("rst_mem_we", bus.mem_we, 0);
    check("rst_mem_re", bus.mem_re, 0);
    check("rst_mem_addr", bus.mem_address, 0);
    check("rst_mem_wd", bus.mem_wd, 0);
    check("rst_m0_rd", bus.m0_rd, 0);
    check("rst_m1_rd", bus.m1_rd, 0);
    check("rst_gnt", bus.gnt_id, 0);
    rst    = 1'b0;
    mon_en = 1'b1;
    @(negedge clk);

    do_req(0, 0, 32'd20, 32'd0, lat);
    check("rd20_data", bus.m0_rd, 32'hDEAD_BEEF);
    check("rd20_lat", lat, 2);
    check("rd20_m1_ack", bus.m1_ack, 0);
    set_req(0, 1'b0);
    @(negedge clk);

    do_req(1, 1, 32'd25, 32'h1234_5678, lat);
    set_req(1, 1'b0);
    @(negedge clk);
    do_req(1, 0, 32'd25, 32'd0, lat);
    check("rd25_data", bus.m1_rd, 32'h1234_5678);
    check("rd25_lat", lat, 2);
    set_req(1, 1'b0);
    @(negedge clk);

    do_reset();
    fork
      begin do_req(0, 0, 32'd5, 32'd0, lat0); set_req(0, 1'b0); end
      begin do_req(1, 0, 32'd6, 32'd0, lat1); set_req(1, 1'b0); end
    join
    check("tie_m0_lat", lat0, 2);
    check("tie_m1_lat", lat1, 5);
    @(negedge clk);

    fork
      contend(0);
      contend(1);
    join
    @(negedge clk);

    set_cmd(1, 1, 32'd30, 32'hCAFE_F00D);
    @(negedge clk);
    check("rstacc_we", bus.mem_we, 1);
    rst = 1'b1;
    @(negedge clk);
    set_req(1, 1'b0);
    rst = 1'b0;
    check("rstacc_busy", bus.busy, 0);
    check("rstacc_we_off", bus.mem_we, 0);
    check("rstacc_addr", bus.mem_address, 0);
    check("rstacc_wd", bus.mem_wd, 0);
    check("rstacc_gnt", bus.gnt_id, 0);
    repeat (3) @(negedge clk);
    check("rstacc_mem", mem_arr[30], 32'hCAFE_F00D);

    set_cmd(0, 0, 32'd7, 32'd0);
    @(negedge clk);
    set_req(0, 1'b0);
    @(negedge clk);
    check("drop_ack", bus.m0_ack, 1);
    repeat (4) @(negedge clk);
    check("drop_busy", bus.busy, 0);
    check("drop_noq", q.size(), 0);

    fork
      rand_traffic(0, 40);
      rand_traffic(1, 40);
    join
    repeat (6) @(negedge clk);
    check("sb_drained", q.size(), 0);
    check("write_count", act_writes, exp_writes);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/data_mem_arbiter.md
# data_mem_arbiter

Two-master arbiter that shares the single-port data memory (async read, sync write) between two requesters, e.g. the core load/store path (m0) and a debug/DMA loader (m1). Each request is accepted with a round-robin grant, registered, issued to memory for exactly one cycle, and answered with a one-cycle ack carrying the read data. It sits directly between the requesters and `data_memory`, driving that memory's `we`, `re`, `address` and `wd` and sampling its `rd`.

## Interface
- DATA_WIDTH, 32, width of write/read data
- ADDR_WIDTH, 32, width of word address passed to memory
- clk  in  1  single clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- m0_req, m1_req  in  1  access request; held high until matching ack
- m0_we, m1_we  in  1  1 = write, 0 = read; stable while req high
- m0_addr, m1_addr  in  ADDR_WIDTH  word address; stable while req high
- m0_wd, m1_wd  in  DATA_WIDTH  write data; stable while req high
- m0_ack, m1_ack  out  1  one-cycle completion pulse
- m0_rd, m1_rd  out  DATA_WIDTH  read data, valid in the ack cycle; held until next ack to that master
- mem_we  out  1  to memory `we`
- mem_re  out  1  to memory `re`
- mem_address  out  ADDR_WIDTH  to memory `address`
- mem_wd  out  DATA_WIDTH  to memory `wd`
- mem_rd  in  DATA_WIDTH  from memory `rd` (combinational)
- busy  out  1  high in ACCESS and RESP
- gnt_id  out  1  master owning the current/last access

## Operation
- FSM states: IDLE, ACCESS, RESP.
- IDLE: if any req high, pick winner, latch its we/addr/wd into command registers, set gnt_id, go ACCESS. Otherwise stay.
- Arbitration: one requester wins outright. If both request, the winner is the master not equal to last_grant, then last_grant <= winner. last_grant resets to 1, so m0 wins the first tie.
- ACCESS (one cycle):
  - mem_address = cmd_addr and mem_wd = cmd_wd.
  - mem_we = cmd_we and mem_re = ~cmd_we.
  - Capture mem_rd into the rd register of the granted master, for reads only; writes leave that rd register unchanged.
  - Go RESP.
- RESP (one cycle): assert ack of granted master only; mem_we = mem_re = 0; go IDLE unconditionally.
- mem_address and mem_wd hold their last value outside ACCESS. mem_we is never high outside ACCESS, so exactly one write per write request.
- The non-granted master's req stays pending; it is served from IDLE after RESP.
- Req dropped mid-access: the access still completes and the ack still pulses.
- Req still high in the cycle after ack: treated as a new request.
- No address range checking; addresses pass through unchanged.

## Timing
- Reset values:
  - state IDLE, last_grant 1, gnt_id 0, busy 0.
  - m0_ack, m1_ack 0; m0_rd, m1_rd 0.
  - mem_we, mem_re 0; mem_address 0; mem_wd 0.
- Latency:
  - req high sampled at edge N (state IDLE).
  - ACCESS during cycle N+1: memory write commits at edge N+2, or read data is captured at edge N+2.
  - ack high during cycle N+2.
- Throughput: one access per 3 cycles. With both masters continuously requesting, grants strictly alternate.
- Ack is exactly one cycle wide and never asserted on both masters in the same cycle.
- Reset mid-operation: at the reset edge the state returns to IDLE with no ack pulse. Any write that was in ACCESS at that edge has already been presented for that edge; no further mem_we is issued.
- Reset has priority over all requests.

## Test plan
- Single read: preload memory word 20 = 0xDEADBEEF; m0 reads addr 20 at edge 1 -> mem_re high in cycle 2, m0_ack high in cycle 3 with m0_rd = 0xDEADBEEF, m1_ack stays 0.
- Single write then read: m1 writes 0x12345678 to addr 25 -> mem_we high for exactly one cycle; a following m1 read of addr 25 returns 0x12345678 with ack 3 cycles after request.
- Simultaneous requests after reset: m0 and m1 both request reads -> m0 acked first (gnt_id 0), m1 acked 3 cycles later (gnt_id 1).
- Continuous contention: both req held high for 12 cycles -> acks alternate m0, m1, m0, m1; no cycle has both acks high.
- Reset in ACCESS: assert rst during a write's ACCESS cycle -> next cycle state IDLE, all outputs at reset values, no ack, no second mem_we.
- Early req drop: m0 drops req the cycle after grant -> m0_ack still pulses in RESP, and no new access starts.
